store_path_unit: RTL and testbench
==================================

Name: store_path_unit

Overview:
- Store-side counterpart of the core's writeback/load select path.
- Takes one store per cycle from the execute stage and decodes the address region.
- Aligns the data and generates byte write enables for DMEM and IMEM.
- Sends UART TX MMIO writes through a valid/ready handshake; stalls the pipeline while a UART byte is still pending.

Parameters:
- DMEM_AW, 14, DMEM word-address width.
- IMEM_AW, 14, IMEM word-address width.
- UART_TX_ADDR, 32'h80000008, MMIO address of the UART transmit byte.
- CNT_RST_ADDR, 32'h80000018, MMIO address of the cycle/instruction counter reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous, active-low reset.
- st_valid  in  1  store presented this cycle.
- st_funct3  in  3  000 SB, 001 SH, 010 SW; any other value is treated as no store.
- st_addr  in  32  byte address.
- st_data  in  32  rs2 value, unaligned.
- pc30  in  1  bit 30 of the store instruction's PC; 1 means the core is executing from BIOS.
- st_stall  out  1  store not accepted this cycle; the pipeline must hold.
- dmem_we  out  4  byte write enables.
- dmem_addr  out  DMEM_AW  word address.
- dmem_din  out  32  lane-aligned data.
- imem_we  out  4  byte write enables.
- imem_addr  out  IMEM_AW  word address.
- imem_din  out  32  lane-aligned data.
- uart_tx_valid  out  1  TX byte pending.
- uart_tx_data  out  8  TX byte.
- uart_tx_ready  in  1  UART accepts the byte.
- cnt_rst  out  1  one-cycle counter reset pulse.
- misalign_err  out  1  sticky misaligned-store flag (optional feature only).

Behaviour:
- Region decode on st_addr[31:28]:
  - 0001: DMEM.
  - 0011: DMEM and IMEM.
  - 0010: IMEM only.
  - 0100: BIOS, read-only; store is dropped silently.
  - 1000: MMIO.
  - Anything else: dropped.
- IMEM writes occur only when pc30==1. With pc30==0, the IMEM part of a store is dropped; the DMEM part of region 0011 still writes.
- Lane alignment, with off = st_addr[1:0]:
  - SB: mask 0001<<off; data = {4{st_data[7:0]}}.
  - SH: mask 0011<<{off[1],1'b0}; data = {2{st_data[15:0]}}.
  - SW: mask 1111; data = st_data.
- Word address is st_addr[DMEM_AW+1:2] (IMEM likewise with IMEM_AW).
- Latency: all memory and MMIO outputs are registered and appear exactly 1 cycle after an accepted store. we values are 0 in every cycle without an accepted store of that region.
- cnt_rst pulses high for 1 cycle when any accepted store hits CNT_RST_ADDR. Data is ignored.
- UART FSM, states IDLE and TX_WAIT:
  - In IDLE, an accepted store to UART_TX_ADDR latches st_data[7:0] into uart_tx_data. Next cycle uart_tx_valid=1 and the state becomes TX_WAIT.
  - In TX_WAIT, uart_tx_valid and uart_tx_data are held stable until uart_tx_ready==1. In that cycle the transfer completes; next cycle uart_tx_valid=0 and the state returns to IDLE.
  - If uart_tx_ready is already 1 on the first valid cycle, completion takes 1 cycle.
- Stall: st_stall = st_valid && (state==TX_WAIT). Combinational; the stalled store has no side effect. The store is re-presented and accepted in the cycle after the handshake completes, which preserves ordering.
- A store with st_valid low never stalls.
- Reset, including reset mid-TX_WAIT, applies these values; a pending UART byte is discarded:
  - state = IDLE.
  - all we = 0.
  - uart_tx_valid = 0, uart_tx_data = 0.
  - cnt_rst = 0, misalign_err = 0.
  - addresses and din = 0.
- Non-MMIO, non-IMEM/DMEM addresses in region 1000 are dropped.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined:
  - SH with off[0]==1 is misaligned; SW with off!=0 is misaligned.
  - A misaligned store performs no write (all we=0, no UART, no cnt_rst).
  - misalign_err sets the cycle after such a store and stays set until reset.
- Undefined:
  - Low address bits are truncated to natural alignment and the write proceeds.
  - misalign_err is tied to 0.

Decomposition:
- Shared package store_pkg holds:
  - region codes (REGION_DMEM 4'b0001, REGION_DMIMEM 4'b0011, REGION_IMEM 4'b0010, REGION_BIOS 4'b0100, REGION_MMIO 4'b1000);
  - funct3 store codes;
  - the UART FSM state enum;
  - the default MMIO addresses.
- Sub-module store_align: combinational funct3/offset to mask and lane-data generation, instantiated once and shared by DMEM and IMEM.

Test Plan:
- SB addr 0x10000003, data 0x000000AB -> next cycle dmem_we=1000, dmem_din=0xABABABAB, dmem_addr=0; imem_we=0.
- SW addr 0x30000010, data 0xDEADBEEF: with pc30=1 -> dmem_we=imem_we=1111, both word addresses =4. With pc30=0 -> only dmem_we=1111.
- SW to 0x40000000 -> all we=0 and no outputs change.
- UART flow: SB 0x80000008 data 0x41 with uart_tx_ready=0 for 3 cycles:
  - uart_tx_valid=1, uart_tx_data=0x41 held;
  - a second store is stalled 3 cycles and accepted the cycle after the ready handshake.
- Store to 0x80000018 -> cnt_rst high exactly 1 cycle; rst_n low during TX_WAIT -> uart_tx_valid=0 next cycle and state=IDLE.
- STORE_MISALIGN_TRAP_EN: SH addr 0x10000001 -> dmem_we=0 and misalign_err=1 sticky. Without the macro -> dmem_we=0011.

Source files
------------

// File: rtl/store_pkg.sv
// Shared constants for the store path: region codes, store funct3 codes,
// UART TX state encoding and default MMIO addresses.
package store_pkg;

  localparam logic [3:0] REGION_DMEM   = 4'b0001;
  localparam logic [3:0] REGION_DMIMEM = 4'b0011;
  localparam logic [3:0] REGION_IMEM   = 4'b0010;
  localparam logic [3:0] REGION_BIOS   = 4'b0100;
  localparam logic [3:0] REGION_MMIO   = 4'b1000;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic {
    UART_IDLE    = 1'b0,
    UART_TX_WAIT = 1'b1
  } uart_state_e;

  localparam logic [31:0] UART_TX_ADDR_DEF = 32'h8000_0008;
  localparam logic [31:0] CNT_RST_ADDR_DEF = 32'h8000_0018;

endpackage

// File: rtl/store_align.sv
// Store lane alignment: funct3 and byte offset to byte mask and replicated
// lane data; also flags whether the access is naturally aligned.
module store_align
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [3:0]  mask,
  output logic [31:0] lane_data,
  output logic        is_store,
  output logic        misaligned
);

  always_comb begin
    mask       = 4'b0000;
    lane_data  = 32'h0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_SB: begin
        mask      = 4'b0001 << off;
        lane_data = {4{data[7:0]}};
        is_store  = 1'b1;
      end
      F3_SH: begin
        // off[0] is ignored here; the top decides whether that traps
        mask       = 4'b0011 << {off[1], 1'b0};
        lane_data  = {2{data[15:0]}};
        is_store   = 1'b1;
        misaligned = off[0];
      end
      F3_SW: begin
        mask       = 4'b1111;
        lane_data  = data;
        is_store   = 1'b1;
        misaligned = |off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_path_unit.sv
// Store path: region decode, registered DMEM/IMEM byte writes, UART TX MMIO
// handshake with pipeline stall, and counter-reset pulse.
// Optional macro STORE_MISALIGN_TRAP_EN drops misaligned stores and sets a sticky flag.
module store_path_unit
  import store_pkg::*;
#(
  parameter int          DMEM_AW      = 14,
  parameter int          IMEM_AW      = 14,
  parameter logic [31:0] UART_TX_ADDR = UART_TX_ADDR_DEF,
  parameter logic [31:0] CNT_RST_ADDR = CNT_RST_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               st_valid,
  input  logic [2:0]         st_funct3,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  input  logic               pc30,
  output logic               st_stall,
  output logic [3:0]         dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_din,
  output logic [3:0]         imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_din,
  output logic               uart_tx_valid,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_ready,
  output logic               cnt_rst,
  output logic               misalign_err
);

  uart_state_e state, state_next;

  logic [3:0]  mask;
  logic [31:0] lane_data;
  logic        is_store;
  logic        misaligned;
  logic        trap;
  logic        accept;
  logic [3:0]  region;
  logic        dmem_hit;
  logic        imem_hit;
  logic        uart_hit;
  logic        cnt_hit;

  store_align u_align (
    .funct3     (st_funct3),
    .off        (st_addr[1:0]),
    .data       (st_data),
    .mask       (mask),
    .lane_data  (lane_data),
    .is_store   (is_store),
    .misaligned (misaligned)
  );

  assign st_stall = st_valid && (state == UART_TX_WAIT);

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap = misaligned;

  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_err <= 1'b0;
    else if (st_valid && !st_stall && is_store && misaligned)
      misalign_err <= 1'b1;
  end
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign trap              = 1'b0;
  assign misalign_err      = 1'b0;
`endif

  assign accept   = st_valid && !st_stall && is_store && !trap;
  assign region   = st_addr[31:28];
  assign dmem_hit = accept && ((region == REGION_DMEM) || (region == REGION_DMIMEM));
  // IMEM is writable only while running from BIOS
  assign imem_hit = accept && pc30 && ((region == REGION_IMEM) || (region == REGION_DMIMEM));
  assign uart_hit = accept && (st_addr == UART_TX_ADDR);
  assign cnt_hit  = accept && (st_addr == CNT_RST_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= UART_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      UART_IDLE:    if (uart_hit)      state_next = UART_TX_WAIT;
      UART_TX_WAIT: if (uart_tx_ready) state_next = UART_IDLE;
    endcase
  end

  assign uart_tx_valid = (state == UART_TX_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_we      <= 4'b0000;
      dmem_addr    <= '0;
      dmem_din     <= 32'h0;
      imem_we      <= 4'b0000;
      imem_addr    <= '0;
      imem_din     <= 32'h0;
      uart_tx_data <= 8'h00;
      cnt_rst      <= 1'b0;
    end else begin
      dmem_we <= dmem_hit ? mask : 4'b0000;
      imem_we <= imem_hit ? mask : 4'b0000;
      cnt_rst <= cnt_hit;
      if (dmem_hit) begin
        dmem_addr <= st_addr[DMEM_AW+1:2];
        dmem_din  <= lane_data;
      end
      if (imem_hit) begin
        imem_addr <= st_addr[IMEM_AW+1:2];
        imem_din  <= lane_data;
      end
      if (uart_hit)
        uart_tx_data <= st_data[7:0];
    end
  end

endmodule

// File: tb/tb_store_path_unit.sv
// Self-checking bench for store_path_unit: directed table, UART/counter/reset
// sequences, and randomized traffic against a behavioural model.
module tb_store_path_unit;

  localparam logic [31:0] UART_A = 32'h8000_0008;
  localparam logic [31:0] CNT_A  = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic [2:0]  st_funct3 = 3'd0;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        pc30 = 1'b0;
  logic        uart_tx_ready = 1'b0;
  logic        st_stall;
  logic [3:0]  dmem_we, imem_we;
  logic [13:0] dmem_addr, imem_addr;
  logic [31:0] dmem_din, imem_din;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        cnt_rst;
  logic        misalign_err;

  store_path_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_valid      (st_valid),
    .st_funct3     (st_funct3),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .pc30          (pc30),
    .st_stall      (st_stall),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_din      (dmem_din),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_din      (imem_din),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .cnt_rst       (cnt_rst),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit last_stall;

  // behavioural model state
  bit          m_pend;
  logic [7:0]  m_udata;
  logic [3:0]  m_dwe, m_iwe;
  logic [13:0] m_daddr, m_iaddr;
  logic [31:0] m_ddin, m_idin;
  bit          m_cnt, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit          stall, legal, mis, trap_on, ok;
    int          off;
    logic [3:0]  r;
    logic [3:0]  msk;
    logic [31:0] lane;
    if (!rst_n) begin
      m_pend = 0; m_udata = 0; m_dwe = 0; m_iwe = 0;
      m_daddr = 0; m_iaddr = 0; m_ddin = 0; m_idin = 0;
      m_cnt = 0; m_mis = 0;
      return;
    end
    stall = st_valid && m_pend;
    legal = (st_funct3 <= 3'd2);
    off   = int'(st_addr % 4);
`ifdef STORE_MISALIGN_TRAP_EN
    trap_on = 1;
`else
    trap_on = 0;
`endif
    mis = (st_funct3 == 3'd1 && (off % 2) != 0) || (st_funct3 == 3'd2 && off != 0);
    ok  = st_valid && !stall && legal && !(trap_on && mis);
    if (trap_on && st_valid && !stall && legal && mis) m_mis = 1;
    case (st_funct3)
      3'd0:    begin msk = 4'(1 << off);           lane = {24'h0, st_data[7:0]} * 32'h0101_0101; end
      3'd1:    begin msk = 4'(3 << ((off / 2) * 2)); lane = {16'h0, st_data[15:0]} * 32'h0001_0001; end
      default: begin msk = 4'hF;                   lane = st_data; end
    endcase
    r = st_addr[31:28];
    m_dwe = 0;
    m_iwe = 0;
    if (ok && (r == 4'h1 || r == 4'h3)) begin
      m_dwe = msk; m_daddr = st_addr[15:2]; m_ddin = lane;
    end
    if (ok && pc30 && (r == 4'h2 || r == 4'h3)) begin
      m_iwe = msk; m_iaddr = st_addr[15:2]; m_idin = lane;
    end
    m_cnt = ok && (st_addr == CNT_A);
    if (m_pend) begin
      if (uart_tx_ready) m_pend = 0;
    end else if (ok && st_addr == UART_A) begin
      m_pend = 1; m_udata = st_data[7:0];
    end
  endtask

  task automatic check_all();
    chk("dmem_we",       32'(dmem_we),       32'(m_dwe));
    chk("dmem_addr",     32'(dmem_addr),     32'(m_daddr));
    chk("dmem_din",      dmem_din,           m_ddin);
    chk("imem_we",       32'(imem_we),       32'(m_iwe));
    chk("imem_addr",     32'(imem_addr),     32'(m_iaddr));
    chk("imem_din",      imem_din,           m_idin);
    chk("uart_tx_valid", 32'(uart_tx_valid), 32'(m_pend));
    chk("uart_tx_data",  32'(uart_tx_data),  32'(m_udata));
    chk("cnt_rst",       32'(cnt_rst),       32'(m_cnt));
    chk("misalign_err",  32'(misalign_err),  32'(m_mis));
  endtask

  task automatic cyc(input bit v, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input bit pc, input bit rdy);
    @(negedge clk);
    st_valid = v; st_funct3 = f3; st_addr = a; st_data = d;
    pc30 = pc; uart_tx_ready = rdy;
    #1;
    last_stall = st_stall;
    chk("st_stall", 32'(st_stall), 32'(st_valid && m_pend));
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    bit          pc;
    logic [3:0]  dwe;
    logic [31:0] ddin;
    logic [13:0] daddr;
    logic [3:0]  iwe;
    logic [13:0] iaddr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int stalls;
    logic [3:0]  reg_sel;
    logic [31:0] a;
    logic [2:0]  f3;

    tbl[0] = '{3'd0, 32'h1000_0003, 32'h0000_00AB, 1'b0, 4'h8, 32'hABAB_ABAB, 14'h0,  4'h0, 14'h0};
    tbl[1] = '{3'd2, 32'h3000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'hDEAD_BEEF, 14'h4,  4'hF, 14'h4};
    tbl[2] = '{3'd2, 32'h3000_0010, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'hDEAD_BEEF, 14'h4,  4'h0, 14'h4};
    tbl[3] = '{3'd2, 32'h4000_0000, 32'h1234_5678, 1'b1, 4'h0, 32'hDEAD_BEEF, 14'h4,  4'h0, 14'h4};
    tbl[4] = '{3'd1, 32'h1000_0006, 32'h0000_CAFE, 1'b0, 4'hC, 32'hCAFE_CAFE, 14'h1,  4'h0, 14'h4};
    tbl[5] = '{3'd0, 32'h2000_0105, 32'h0000_005A, 1'b1, 4'h0, 32'hCAFE_CAFE, 14'h1,  4'h2, 14'h41};
    tbl[6] = '{3'd0, 32'h2000_0105, 32'h0000_005A, 1'b0, 4'h0, 32'hCAFE_CAFE, 14'h1,  4'h0, 14'h41};
    tbl[7] = '{3'd3, 32'h1000_0000, 32'hFFFF_FFFF, 1'b1, 4'h0, 32'hCAFE_CAFE, 14'h1,  4'h0, 14'h41};
`ifdef STORE_MISALIGN_TRAP_EN
    tbl[8] = '{3'd1, 32'h1000_0001, 32'h0000_BEEF, 1'b0, 4'h0, 32'hCAFE_CAFE, 14'h1,  4'h0, 14'h41};
`else
    tbl[8] = '{3'd1, 32'h1000_0001, 32'h0000_BEEF, 1'b0, 4'h3, 32'hBEEF_BEEF, 14'h0,  4'h0, 14'h41};
`endif

    // reset
    rst_n = 1'b0;
    repeat (2) cyc(0, 3'd0, 32'h0, 32'h0, 0, 0);
    chk("rst dmem_we",       32'(dmem_we),       32'h0);
    chk("rst imem_we",       32'(imem_we),       32'h0);
    chk("rst uart_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("rst uart_tx_data",  32'(uart_tx_data),  32'h0);
    chk("rst cnt_rst",       32'(cnt_rst),       32'h0);
    chk("rst misalign_err",  32'(misalign_err),  32'h0);
    chk("rst dmem_din",      dmem_din,           32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cyc(1, tbl[i].f3, tbl[i].addr, tbl[i].data, tbl[i].pc, 0);
      chk($sformatf("tbl%0d dmem_we", i),   32'(dmem_we),   32'(tbl[i].dwe));
      chk($sformatf("tbl%0d dmem_din", i),  dmem_din,       tbl[i].ddin);
      chk($sformatf("tbl%0d dmem_addr", i), 32'(dmem_addr), 32'(tbl[i].daddr));
      chk($sformatf("tbl%0d imem_we", i),   32'(imem_we),   32'(tbl[i].iwe));
      chk($sformatf("tbl%0d imem_addr", i), 32'(imem_addr), 32'(tbl[i].iaddr));
    end
    cyc(0, 3'd0, 32'h0, 32'h0, 0, 0);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("misalign sticky", 32'(misalign_err), 32'h1);
`else
    chk("misalign tied", 32'(misalign_err), 32'h0);
`endif

    // UART handshake with a stalled follower store
    cyc(1, 3'd0, UART_A, 32'h0000_0041, 0, 0);
    chk("uart valid set", 32'(uart_tx_valid), 32'h1);
    chk("uart data",      32'(uart_tx_data),  32'h41);
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 3'd2, 32'h1000_0020, 32'h1111_2222, 0, (k == 2));
      stalls += int'(last_stall);
      chk("stalled no write", 32'(dmem_we), 32'h0);
      if (k < 2) begin
        chk("uart valid held", 32'(uart_tx_valid), 32'h1);
        chk("uart data held",  32'(uart_tx_data),  32'h41);
      end
    end
    chk("uart valid cleared", 32'(uart_tx_valid), 32'h0);
    cyc(1, 3'd2, 32'h1000_0020, 32'h1111_2222, 0, 0);
    chk("follower accepted", 32'(last_stall), 32'h0);
    chk("uart stalls", 32'(stalls), 32'd3);
    chk("follower dmem_we",   32'(dmem_we),   32'hF);
    chk("follower dmem_addr", 32'(dmem_addr), 32'h8);

    // counter reset pulse
    cyc(1, 3'd2, CNT_A, 32'hFFFF_FFFF, 0, 0);
    chk("cnt_rst pulse", 32'(cnt_rst), 32'h1);
    cyc(0, 3'd0, 32'h0, 32'h0, 0, 0);
    chk("cnt_rst low", 32'(cnt_rst), 32'h0);

    // reset while a byte is pending
    cyc(1, 3'd0, UART_A, 32'h0000_0055, 0, 0);
    chk("uart pend", 32'(uart_tx_valid), 32'h1);
    rst_n = 1'b0;
    cyc(0, 3'd0, 32'h0, 32'h0, 0, 0);
    chk("rst mid valid", 32'(uart_tx_valid), 32'h0);
    chk("rst mid data",  32'(uart_tx_data),  32'h0);
    rst_n = 1'b1;
    cyc(1, 3'd0, 32'h1000_0000, 32'h0000_0077, 0, 0);
    chk("post rst no stall", 32'(last_stall), 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: a = {4'h1, 28'($urandom)};
        1: a = {4'h3, 28'($urandom)};
        2: a = {4'h2, 28'($urandom)};
        3: a = {4'h4, 28'($urandom)};
        4: a = UART_A;
        5: a = CNT_A;
        6: a = {4'h8, 28'($urandom)};
        default: a = $urandom;
      endcase
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      reg_sel = 4'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(reg_sel != 0, f3, a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end
    rst_n = 1'b1;
    cyc(0, 3'd0, 32'h0, 32'h0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
